// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider and the EX stage that drives it.
package div_pkg;

    localparam int DIV_DATA_W = 32;

    // Divider control FSM encodings.
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    // Levels of ready_o.
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Levels of start_i.
    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    // ALU op codes EX decodes to raise start_i and choose signed_div_i.
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage : div_pkg

// File: rtl/div.sv
// Restoring shift-subtract 32-bit divider, one quotient bit per clock.
// Handshake: EX holds start_i high until it sees ready_o; result_o is valid
// while ready_o is high; dropping start_i in END releases the divider back to
// FREE and clears the result. annul_i aborts a division in progress.
module div
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    localparam int CNT_W  = $clog2(DATA_W) + 1;
    localparam int WORK_W = 2 * DATA_W + 1;

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORK_W-1:0]   work_q, work_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                dvd_neg_q, dvd_neg_d;
    logic                quo_neg_q, quo_neg_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    // Trial subtraction; bit DATA_W set means the divisor did not fit.
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   dvd_mag;
    logic [DATA_W-1:0]   dsr_mag;
    logic [DATA_W-1:0]   quo_mag;
    logic [DATA_W-1:0]   rem_mag;

    assign diff    = {1'b0, work_q[2*DATA_W-1:DATA_W]} - {1'b0, divisor_q};
    assign dvd_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign dsr_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    assign quo_mag = work_q[DATA_W-1:0];
    assign rem_mag = work_q[WORK_W-1:DATA_W+1];

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            dvd_neg_q <= 1'b0;
            quo_neg_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            dvd_neg_q <= dvd_neg_d;
            quo_neg_q <= quo_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state and datapath update for the divider FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        dvd_neg_d = dvd_neg_q;
        quo_neg_d = quo_neg_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            DivFree: begin
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = DivByZero;
                    end else begin
                        state_d   = DivOn;
                        cnt_d     = '0;
                        dvd_neg_d = signed_div_i & opdata1_i[DATA_W-1];
                        quo_neg_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        divisor_d = dsr_mag;
                        // Guard bit + zero upper half + |dividend|, pre-shifted by one.
                        work_d    = {{DATA_W{1'b0}}, dvd_mag, 1'b0};
                    end
                end
            end

            DivByZero: begin
                work_d   = '0;
                result_d = '0;
                ready_d  = DivResultReady;
                state_d  = DivEnd;
            end

            DivOn: begin
                if (annul_i) begin
                    state_d = DivFree;
                end else if (cnt_q != CNT_W'(DATA_W)) begin
                    if (diff[DATA_W]) begin
                        work_d = {work_q[WORK_W-2:0], 1'b0};
                    end else begin
                        work_d = {diff[DATA_W-1:0], work_q[DATA_W-1:0], 1'b1};
                    end
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    // Remainder takes the sign of the dividend.
                    result_d = {dvd_neg_q ? -rem_mag : rem_mag,
                                quo_neg_q ? -quo_mag : quo_mag};
                    ready_d  = DivResultReady;
                    state_d  = DivEnd;
                end
            end

            DivEnd: begin
                // A start_i still high here is the old request, not a new one.
                if (start_i == DivStop) begin
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                    state_d  = DivFree;
                end
            end

            default: begin
                state_d = DivFree;
            end
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule : div
